// File: rtl/afifo_pkg.sv
// -----------------------------------------------------------------------------
// afifo_pkg
// Shared types and helpers for the async-FIFO write-side arbiter.
//   arb_state_e : arbiter FSM state (idle / burst in progress)
//   tag_width() : width of the source tag carried in the FIFO word MSBs
// -----------------------------------------------------------------------------
package afifo_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  // A tag is never narrower than one bit, even for two requesters.
  function automatic int tag_width(input int n);
    int w;
    if (n <= 2) begin
      w = 1;
    end else begin
      w = $clog2(n);
    end
    return w;
  endfunction

endpackage

// File: rtl/afifo_rr_pick.sv
// -----------------------------------------------------------------------------
// afifo_rr_pick
// Combinational round-robin picker: returns the first set bit of i_req found
// scanning upward from i_start, wrapping modulo NUM_REQ.
// Ports:
//   i_req    [NUM_REQ]   request vector
//   i_start  [TAG_WIDTH] first index examined (must be < NUM_REQ)
//   o_found  [1]         at least one request is set
//   o_idx    [TAG_WIDTH] winning index (0 when nothing is found)
// -----------------------------------------------------------------------------
module afifo_rr_pick
  import afifo_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int TAG_WIDTH = tag_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [TAG_WIDTH-1:0] i_start,
  output logic                 o_found,
  output logic [TAG_WIDTH-1:0] o_idx
);

  int w_pos;

  // Priority scan starting at i_start; the wrap is a conditional subtract
  // because i_start is always below NUM_REQ.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_pos   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos = int'(i_start) + k;
      if (w_pos >= NUM_REQ) begin
        w_pos = w_pos - NUM_REQ;
      end else begin
        w_pos = w_pos;
      end
      if (!o_found && i_req[w_pos]) begin
        o_found = 1'b1;
        o_idx   = TAG_WIDTH'(w_pos);
      end else begin
        o_found = o_found;
      end
    end
  end

endmodule

// File: rtl/afifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// afifo_wr_arbiter
// Shares the single write port of an async FIFO between NUM_REQ requesters in
// the wr_clk domain. One requester is granted at a time in round-robin order;
// a grant lasts until the packet ends, MAX_BURST beats have been accepted, or
// the granted requester drops valid. Each FIFO word carries the source tag in
// its MSBs so the read side can demultiplex interleaved packets.
// Ports:
//   wr_clk          write-domain clock
//   wr_rst_n        asynchronous active-low reset
//   i_req_valid     [NUM_REQ]             per-requester beat valid
//   i_req_data      [NUM_REQ*DATA_WIDTH]  requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   i_req_last      [NUM_REQ]             last beat of the requester's packet
//   o_req_ready     [NUM_REQ]             per-requester accept (valid&&ready = transfer)
//   i_fifo_full     FIFO full flag
//   o_fifo_wr_en    FIFO write enable
//   o_fifo_wr_data  [TAG_WIDTH+DATA_WIDTH] {grant_id, payload}
//   o_grant_id      [TAG_WIDTH]           current or last granted requester
//   o_busy          high while a grant is active
// -----------------------------------------------------------------------------
module afifo_wr_arbiter
  import afifo_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int TAG_WIDTH  = tag_width(NUM_REQ)
) (
  input  logic                            wr_clk,
  input  logic                            wr_rst_n,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_data,
  input  logic [NUM_REQ-1:0]              i_req_last,
  output logic [NUM_REQ-1:0]              o_req_ready,
  input  logic                            i_fifo_full,
  output logic                            o_fifo_wr_en,
  output logic [TAG_WIDTH+DATA_WIDTH-1:0] o_fifo_wr_data,
  output logic [TAG_WIDTH-1:0]            o_grant_id,
  output logic                            o_busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]     CNT_CAP_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0]     CNT_SAT      = CNT_W'(MAX_BURST);
  localparam logic [TAG_WIDTH-1:0] TAG_TOP      = TAG_WIDTH'(NUM_REQ - 1);

  arb_state_e             r_state;
  logic [TAG_WIDTH-1:0]   r_grant_id;
  logic [TAG_WIDTH-1:0]   r_rr_last;
  logic [CNT_W-1:0]       r_beat_cnt;

  logic                   w_in_burst;
  logic                   w_gnt_valid;
  logic                   w_gnt_last;
  logic [DATA_WIDTH-1:0]  w_gnt_data;
  logic                   w_accept;
  logic                   w_release;
  logic [TAG_WIDTH-1:0]   w_scan_base;
  logic [TAG_WIDTH-1:0]   w_scan_start;
  logic                   w_pick_found;
  logic [TAG_WIDTH-1:0]   w_pick_idx;
  logic [NUM_REQ-1:0]     w_ready;

  // The reset term keeps the write port quiet combinationally while reset is low.
  assign w_in_burst  = wr_rst_n && (r_state == ARB_BURST);
  assign w_gnt_valid = i_req_valid[r_grant_id];
  assign w_gnt_last  = i_req_last[r_grant_id];
  assign w_gnt_data  = i_req_data[int'(r_grant_id)*DATA_WIDTH +: DATA_WIDTH];
  assign w_accept    = w_in_burst && w_gnt_valid && !i_fifo_full;

  // Full never releases the grant; a stalled requester always does.
  assign w_release   = w_in_burst &&
                       ((w_accept && (w_gnt_last || (r_beat_cnt == CNT_CAP_LAST))) ||
                        !w_gnt_valid);

  // One picker serves both the idle pick and the back-to-back re-pick; only the
  // scan origin differs.
  assign w_scan_base  = (r_state == ARB_IDLE) ? r_rr_last : r_grant_id;
  assign w_scan_start = (w_scan_base == TAG_TOP) ? '0 : (w_scan_base + TAG_WIDTH'(1));

  afifo_rr_pick #(
    .NUM_REQ   (NUM_REQ),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_pick (
    .i_req   (i_req_valid),
    .i_start (w_scan_start),
    .o_found (w_pick_found),
    .o_idx   (w_pick_idx)
  );

  // Ready goes only to the granted requester, and only while the FIFO has room.
  always_comb begin
    w_ready = '0;
    if (w_in_burst) begin
      w_ready[r_grant_id] = !i_fifo_full;
    end else begin
      w_ready = '0;
    end
  end

  assign o_req_ready    = w_ready;
  assign o_fifo_wr_en   = w_accept;
  assign o_fifo_wr_data = {r_grant_id, w_gnt_data};
  assign o_grant_id     = r_grant_id;
  assign o_busy         = (r_state == ARB_BURST);

  // Arbiter FSM: grant selection, burst counting and release / re-arbitration.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      r_state    <= ARB_IDLE;
      r_rr_last  <= TAG_TOP;
      r_beat_cnt <= '0;
      r_grant_id <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_pick_found) begin
            r_grant_id <= w_pick_idx;
            r_beat_cnt <= '0;
            r_state    <= ARB_BURST;
          end else begin
            r_state    <= ARB_IDLE;
          end
        end
        ARB_BURST: begin
          if (w_release) begin
            r_rr_last <= r_grant_id;
            if (w_pick_found) begin
              // Zero-bubble handover; may re-pick the same requester only if
              // nobody else is valid.
              r_grant_id <= w_pick_idx;
              r_beat_cnt <= '0;
              r_state    <= ARB_BURST;
            end else begin
              r_state    <= ARB_IDLE;
            end
          end else if (w_accept && (r_beat_cnt != CNT_SAT)) begin
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
          end else begin
            r_beat_cnt <= r_beat_cnt;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_afifo_wr_arbiter
// Directed bench for afifo_wr_arbiter. Each requester is a queue of beats that
// pops on valid&&ready; a behavioural scheduler model predicts the write port
// every cycle, and the FIFO write log is pinned with hand-computed sequences.
// -----------------------------------------------------------------------------
module tb_afifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          wr_clk;
  logic          wr_rst_n;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_last;
  logic [N-1:0]  req_ready;
  logic          fifo_full;
  logic          fifo_wr_en;
  logic [9:0]    fifo_wr_data;
  logic [1:0]    grant_id;
  logic          busy;

  afifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .wr_clk         (wr_clk),
    .wr_rst_n       (wr_rst_n),
    .i_req_valid    (req_valid),
    .i_req_data     (req_data),
    .i_req_last     (req_last),
    .o_req_ready    (req_ready),
    .i_fifo_full    (fifo_full),
    .o_fifo_wr_en   (fifo_wr_en),
    .o_fifo_wr_data (fifo_wr_data),
    .o_grant_id     (grant_id),
    .o_busy         (busy)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // requester sources: {last, data}
  logic [8:0] src_mem [N][0:15];
  int head [N];
  int tail [N];
  logic [N-1:0] stall;
  logic [N-1:0] hs;

  // FIFO write log
  logic [9:0] got_w [0:63];
  int got_c [0:63];
  int got_n = 0;
  int cyc = 0;

  // scheduler model
  int m_owner, m_prev, m_beats, m_tag;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int rr_next(input int from, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  // every-cycle compare against the model, plus write logging
  always @(negedge wr_clk) begin : cmp_blk
    int g, p;
    logic took, done;
    logic [N-1:0] e_rdy;
    cyc++;
    hs = req_ready & req_valid;
    if (fifo_wr_en && got_n < 64) begin
      got_w[got_n] = fifo_wr_data;
      got_c[got_n] = cyc;
      got_n++;
    end
    if (!wr_rst_n) begin
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_grant", 32'(grant_id), 32'd0);
      m_owner = -1; m_prev = N - 1; m_beats = 0; m_tag = 0;
    end else if (m_owner < 0) begin
      chk("idle_ready", 32'(req_ready), 32'd0);
      chk("idle_wr_en", 32'(fifo_wr_en), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_grant", 32'(grant_id), 32'(m_tag));
      p = rr_next(m_prev, req_valid);
      if (p >= 0) begin
        m_owner = p; m_tag = p; m_beats = 0;
      end
    end else begin
      g = m_owner;
      e_rdy = '0;
      if (!fifo_full) e_rdy[g] = 1'b1;
      took = req_valid[g] && !fifo_full;
      chk("burst_ready", 32'(req_ready), 32'(e_rdy));
      chk("burst_wr_en", 32'(fifo_wr_en), 32'(took));
      chk("burst_busy", 32'(busy), 32'd1);
      chk("burst_grant", 32'(grant_id), 32'(g));
      if (took) chk("wr_data", 32'(fifo_wr_data), 32'({2'(g), req_data[g*DW +: DW]}));
      done = (took && (req_last[g] || (m_beats + 1 == MB))) || !req_valid[g];
      if (took) m_beats++;
      if (done) begin
        m_prev = g;
        p = rr_next(g, req_valid);
        if (p >= 0) begin
          m_owner = p; m_tag = p; m_beats = 0;
        end else begin
          m_owner = -1;
        end
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (head[i] < tail[i]) && !stall[i];
      req_data[i*DW +: DW] = (head[i] < tail[i]) ? src_mem[i][head[i]][7:0] : 8'h00;
      req_last[i] = (head[i] < tail[i]) ? src_mem[i][head[i]][8] : 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge wr_clk);
    #1;
    for (int i = 0; i < N; i++) if (hs[i]) head[i]++;
    drive();
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    src_mem[r][tail[r]] = {l, d};
    tail[r]++;
    drive();
  endtask

  task automatic wait_writes(input string nm, input int target);
    int b;
    b = 0;
    while (got_n < target && b < 60) begin
      tick();
      b++;
    end
    if (got_n < target) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: got %0d writes expected %0d", nm, got_n, target);
    end
  endtask

  task automatic check_log(input string nm, input int base, input int n, input logic [9:0] e [0:7]);
    for (int k = 0; k < n; k++) begin
      chk(nm, 32'((base + k < got_n) ? got_w[base + k] : 10'h3FF), 32'(e[k]));
    end
  endtask

  task automatic reset_dut();
    wr_rst_n = 1'b0;
    repeat (2) tick();
    wr_rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
    drive();
  endtask

  logic [9:0] e1 [0:7] = '{10'h0A1, 10'h0A2, 10'h0A3, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0};
  logic [9:0] e2 [0:7] = '{10'h040, 10'h141, 10'h242, 10'h343, 10'h050, 10'h151, 10'h252, 10'h353};
  logic [9:0] e3 [0:7] = '{10'h110, 10'h111, 10'h112, 10'h113, 10'h220, 10'h221, 10'h114, 10'h115};
  logic [9:0] e4 [0:7] = '{10'h0B0, 10'h0B1, 10'h0B2, 10'h0B3, 10'h33C, 10'h0B4, 10'h0B5, 10'h0};
  logic [9:0] e5 [0:7] = '{10'h2C0, 10'h3D0, 10'h2C1, 10'h2C2, 10'h0, 10'h0, 10'h0, 10'h0};
  logic [9:0] e6 [0:7] = '{10'h1E0, 10'h0F0, 10'h1E1, 10'h1E2, 10'h0, 10'h0, 10'h0, 10'h0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n0;
    wr_rst_n  = 1'b1;
    fifo_full = 1'b0;
    stall     = '0;
    for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
    drive();
    #2 wr_rst_n = 1'b0;
    repeat (2) tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_grant", 32'(grant_id), 32'd0);
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_wr_en", 32'(fifo_wr_en), 32'd0);
    wr_rst_n = 1'b1;
    tick();

    // single requester, 3-beat packet
    base = got_n;
    push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b0); push(0, 8'hA3, 1'b1);
    tick();
    chk("t1_busy_c1", 32'(busy), 32'd1);
    chk("t1_ready_c1", 32'(req_ready), 32'h1);
    wait_writes("t1", base + 3);
    check_log("t1_log", base, 3, e1);
    chk("t1_consecutive", 32'(got_c[base + 2] - got_c[base]), 32'd2);
    repeat (2) tick();
    chk("t1_idle", 32'(busy), 32'd0);
    chk("t1_grant_hold", 32'(grant_id), 32'd0);

    // round-robin, all four valid with 1-beat packets
    reset_dut();
    base = got_n;
    for (int r = 0; r < N; r++) push(r, 8'(8'h40 + r), 1'b1);
    for (int r = 0; r < N; r++) push(r, 8'(8'h50 + r), 1'b1);
    wait_writes("t2", base + 8);
    check_log("t2_log", base, 8, e2);
    chk("t2_no_bubble", 32'(got_c[base + 7] - got_c[base]), 32'd7);
    repeat (3) tick();

    // burst cap: requester 1 six beats without last, requester 2 two beats
    base = got_n;
    for (int k = 0; k < 6; k++) push(1, 8'(8'h10 + k), 1'b0);
    push(2, 8'h20, 1'b0); push(2, 8'h21, 1'b1);
    wait_writes("t3", base + 8);
    check_log("t3_log", base, 8, e3);
    repeat (3) tick();

    // backpressure mid-burst, requester 3 waiting
    base = got_n;
    for (int k = 0; k < 6; k++) push(0, 8'(8'hB0 + k), (k == 5) ? 1'b1 : 1'b0);
    wait_writes("t4a", base + 1);
    push(3, 8'h3C, 1'b1);
    wait_writes("t4b", base + 2);
    fifo_full = 1'b1;
    n0 = got_n;
    tick();
    chk("t4_full_ready", 32'(req_ready), 32'd0);
    chk("t4_full_wr_en", 32'(fifo_wr_en), 32'd0);
    repeat (4) tick();
    chk("t4_full_no_write", 32'(got_n), 32'(n0));
    fifo_full = 1'b0;
    wait_writes("t4c", base + 7);
    check_log("t4_log", base, 7, e4);
    chk("t4_total", 32'(got_n - base), 32'd7);
    repeat (3) tick();

    // stall release hands the grant to requester 3
    base = got_n;
    push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b0); push(2, 8'hC2, 1'b1);
    push(3, 8'hD0, 1'b1);
    wait_writes("t5a", base + 1);
    stall[2] = 1'b1;
    drive();
    tick();
    chk("t5_grant_moves", 32'(grant_id), 32'd3);
    stall[2] = 1'b0;
    drive();
    wait_writes("t5b", base + 4);
    check_log("t5_log", base, 4, e5);
    repeat (3) tick();

    // reset during the second beat
    base = got_n;
    push(1, 8'hE0, 1'b0); push(1, 8'hE1, 1'b0); push(1, 8'hE2, 1'b1);
    wait_writes("t6a", base + 1);
    wr_rst_n = 1'b0;
    #1;
    chk("t6_rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("t6_rst_ready", 32'(req_ready), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    wr_rst_n = 1'b1;
    push(0, 8'hF0, 1'b1);
    tick();
    chk("t6_first_grant", 32'(grant_id), 32'd0);
    chk("t6_first_busy", 32'(busy), 32'd1);
    wait_writes("t6b", base + 4);
    check_log("t6_log", base, 4, e6);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
